// File: rtl/mem_pkg.sv
// Shared memory-channel constants and the write-burst state encoding used by
// the instruction/data-cache arbiter in front of backup memory.
package mem_pkg;
   localparam int MEM_ADDR_BITS = 28;
   localparam int MEM_DATA_BITS = 128;
   localparam int MEM_TAG_BITS  = 5;
   localparam int BEATS         = 4;
   localparam int BEAT_BITS     = $clog2(BEATS);

   typedef enum logic {
      IDLE  = 1'b0,
      WDATA = 1'b1
   } arb_state_e;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin grant; the pointer records the last granted port and
// only moves when the granted request actually completes a handshake.
module rr_arb2 (
   input  logic clk,
   input  logic reset,
   input  logic req0_i,
   input  logic req1_i,
   input  logic adv_i,
   output logic gnt0_o,
   output logic gnt1_o
);
   logic rr_last_q, rr_last_d;

   // On a tie the port that did not win last time takes the slot.
   always_comb begin
      gnt1_o    = req1_i & (~req0_i | ~rr_last_q);
      gnt0_o    = req0_i & ~gnt1_o;
      rr_last_d = rr_last_q;
      if (adv_i) begin
         rr_last_d = gnt1_o;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_last_q <= 1'b1;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory request channel between the I-cache refill port (0) and
// the D-cache port (1); write data is locked to the writer for a full line.
module mem_arbiter
   import mem_pkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        p0_req_valid,
   output logic                        p0_req_ready,
   input  logic                        p0_req_rw,
   input  logic [MEM_ADDR_BITS-1:0]    p0_req_addr,
   input  logic [MEM_TAG_BITS-2:0]     p0_req_tag,
   input  logic                        p0_req_data_valid,
   output logic                        p0_req_data_ready,
   input  logic [MEM_DATA_BITS-1:0]    p0_req_data_bits,
   input  logic [MEM_DATA_BITS/8-1:0]  p0_req_data_mask,
   output logic                        p0_resp_valid,
   output logic [MEM_TAG_BITS-2:0]     p0_resp_tag,
   output logic [MEM_DATA_BITS-1:0]    p0_resp_data,
   input  logic                        p1_req_valid,
   output logic                        p1_req_ready,
   input  logic                        p1_req_rw,
   input  logic [MEM_ADDR_BITS-1:0]    p1_req_addr,
   input  logic [MEM_TAG_BITS-2:0]     p1_req_tag,
   input  logic                        p1_req_data_valid,
   output logic                        p1_req_data_ready,
   input  logic [MEM_DATA_BITS-1:0]    p1_req_data_bits,
   input  logic [MEM_DATA_BITS/8-1:0]  p1_req_data_mask,
   output logic                        p1_resp_valid,
   output logic [MEM_TAG_BITS-2:0]     p1_resp_tag,
   output logic [MEM_DATA_BITS-1:0]    p1_resp_data,
   output logic                        mem_req_valid,
   input  logic                        mem_req_ready,
   output logic                        mem_req_rw,
   output logic [MEM_ADDR_BITS-1:0]    mem_req_addr,
   output logic [MEM_TAG_BITS-1:0]     mem_req_tag,
   output logic                        mem_req_data_valid,
   input  logic                        mem_req_data_ready,
   output logic [MEM_DATA_BITS-1:0]    mem_req_data_bits,
   output logic [MEM_DATA_BITS/8-1:0]  mem_req_data_mask,
   output logic [BEAT_BITS-1:0]        mem_req_data_offset,
   input  logic                        mem_resp_valid,
   input  logic [MEM_TAG_BITS-1:0]     mem_resp_tag,
   input  logic [MEM_DATA_BITS-1:0]    mem_resp_data
);
   arb_state_e             state_q, state_d;
   logic [BEAT_BITS-1:0]   beat_cnt_q, beat_cnt_d;
   logic                   wr_owner_q, wr_owner_d;

   logic in_idle, in_wdata;
   logic gnt0, gnt1;
   logic req_hs, data_hs;

   // While reset is held low every handshake output is forced inactive.
   assign in_idle  = reset & (state_q == IDLE);
   assign in_wdata = reset & (state_q == WDATA);

   rr_arb2 u_rr (
      .clk    (clk),
      .reset  (reset),
      .req0_i (p0_req_valid & in_idle),
      .req1_i (p1_req_valid & in_idle),
      .adv_i  (req_hs),
      .gnt0_o (gnt0),
      .gnt1_o (gnt1)
   );

   always_comb begin
      mem_req_valid = gnt0 | gnt1;
      mem_req_rw    = gnt1 ? p1_req_rw   : p0_req_rw;
      mem_req_addr  = gnt1 ? p1_req_addr : p0_req_addr;
      mem_req_tag   = {gnt1, (gnt1 ? p1_req_tag : p0_req_tag)};
      p0_req_ready  = mem_req_ready & gnt0;
      p1_req_ready  = mem_req_ready & gnt1;
      req_hs        = mem_req_valid & mem_req_ready;
   end

   always_comb begin
      mem_req_data_valid  = in_wdata & (wr_owner_q ? p1_req_data_valid : p0_req_data_valid);
      mem_req_data_bits   = wr_owner_q ? p1_req_data_bits : p0_req_data_bits;
      mem_req_data_mask   = wr_owner_q ? p1_req_data_mask : p0_req_data_mask;
      mem_req_data_offset = beat_cnt_q;
      p0_req_data_ready   = in_wdata & ~wr_owner_q & mem_req_data_ready;
      p1_req_data_ready   = in_wdata &  wr_owner_q & mem_req_data_ready;
      data_hs             = mem_req_data_valid & mem_req_data_ready;
   end

   // Tag MSB selects the port; the remaining bits are the requester's own tag.
   always_comb begin
      p0_resp_valid = reset & mem_resp_valid & ~mem_resp_tag[MEM_TAG_BITS-1];
      p1_resp_valid = reset & mem_resp_valid &  mem_resp_tag[MEM_TAG_BITS-1];
      p0_resp_tag   = mem_resp_tag[MEM_TAG_BITS-2:0];
      p1_resp_tag   = mem_resp_tag[MEM_TAG_BITS-2:0];
      p0_resp_data  = mem_resp_data;
      p1_resp_data  = mem_resp_data;
   end

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      wr_owner_d = wr_owner_q;
      unique case (state_q)
         IDLE: begin
            if (req_hs && mem_req_rw) begin
               state_d    = WDATA;
               wr_owner_d = gnt1;
               beat_cnt_d = '0;
            end
         end
         WDATA: begin
            if (data_hs) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == BEAT_BITS'(BEATS - 1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         wr_owner_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         wr_owner_q <= wr_owner_d;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for arbitration/response
// routing plus hand-written write-burst and reset-abort sequences.
module tb_mem_arbiter;
   import mem_pkg::*;

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        p0_req_valid, p0_req_ready, p0_req_rw;
   logic [MEM_ADDR_BITS-1:0]    p0_req_addr;
   logic [MEM_TAG_BITS-2:0]     p0_req_tag;
   logic                        p0_req_data_valid, p0_req_data_ready;
   logic [MEM_DATA_BITS-1:0]    p0_req_data_bits;
   logic [MEM_DATA_BITS/8-1:0]  p0_req_data_mask;
   logic                        p0_resp_valid;
   logic [MEM_TAG_BITS-2:0]     p0_resp_tag;
   logic [MEM_DATA_BITS-1:0]    p0_resp_data;
   logic                        p1_req_valid, p1_req_ready, p1_req_rw;
   logic [MEM_ADDR_BITS-1:0]    p1_req_addr;
   logic [MEM_TAG_BITS-2:0]     p1_req_tag;
   logic                        p1_req_data_valid, p1_req_data_ready;
   logic [MEM_DATA_BITS-1:0]    p1_req_data_bits;
   logic [MEM_DATA_BITS/8-1:0]  p1_req_data_mask;
   logic                        p1_resp_valid;
   logic [MEM_TAG_BITS-2:0]     p1_resp_tag;
   logic [MEM_DATA_BITS-1:0]    p1_resp_data;
   logic                        mem_req_valid, mem_req_ready, mem_req_rw;
   logic [MEM_ADDR_BITS-1:0]    mem_req_addr;
   logic [MEM_TAG_BITS-1:0]     mem_req_tag;
   logic                        mem_req_data_valid, mem_req_data_ready;
   logic [MEM_DATA_BITS-1:0]    mem_req_data_bits;
   logic [MEM_DATA_BITS/8-1:0]  mem_req_data_mask;
   logic [BEAT_BITS-1:0]        mem_req_data_offset;
   logic                        mem_resp_valid;
   logic [MEM_TAG_BITS-1:0]     mem_resp_tag;
   logic [MEM_DATA_BITS-1:0]    mem_resp_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_rw(p0_req_rw),
      .p0_req_addr(p0_req_addr), .p0_req_tag(p0_req_tag),
      .p0_req_data_valid(p0_req_data_valid), .p0_req_data_ready(p0_req_data_ready),
      .p0_req_data_bits(p0_req_data_bits), .p0_req_data_mask(p0_req_data_mask),
      .p0_resp_valid(p0_resp_valid), .p0_resp_tag(p0_resp_tag), .p0_resp_data(p0_resp_data),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_rw(p1_req_rw),
      .p1_req_addr(p1_req_addr), .p1_req_tag(p1_req_tag),
      .p1_req_data_valid(p1_req_data_valid), .p1_req_data_ready(p1_req_data_ready),
      .p1_req_data_bits(p1_req_data_bits), .p1_req_data_mask(p1_req_data_mask),
      .p1_resp_valid(p1_resp_valid), .p1_resp_tag(p1_resp_tag), .p1_resp_data(p1_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
      .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
      .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
      .mem_req_data_offset(mem_req_data_offset),
      .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] beat_pat(input int k);
      return {4{32'hA0A0_0000 + 32'(k)}};
   endfunction

   // Next-cycle input changes happen just after the rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       v0, v1, ready;
      logic [3:0] t0, t1;
      logic       rv;
      logic [4:0] rtag;
      logic       e_valid;
      logic [4:0] e_tag;
      logic [27:0] e_addr;
      logic       e_r0, e_r1, e_rv0, e_rv1;
      logic [3:0] e_rtag;
   } vec_t;

   vec_t vt [8];

   initial begin
      // Reads only: state stays IDLE, rr_last evolves 1->0->1->0->1->1->1->0->0.
      vt[0] = '{1,0,1, 4'h3,4'h2, 1,5'h03, 1,5'h03,28'h100, 1,0, 1,0, 4'h3};
      vt[1] = '{1,1,1, 4'h1,4'h2, 1,5'h10, 1,5'h12,28'h200, 0,1, 0,1, 4'h0};
      vt[2] = '{1,1,1, 4'h1,4'h2, 1,5'h05, 1,5'h01,28'h100, 1,0, 1,0, 4'h5};
      vt[3] = '{1,1,1, 4'h1,4'h2, 1,5'h1F, 1,5'h12,28'h200, 0,1, 0,1, 4'hF};
      vt[4] = '{1,1,0, 4'h1,4'h2, 0,5'h00, 1,5'h01,28'h100, 0,0, 0,0, 4'h0};
      vt[5] = '{0,1,0, 4'h1,4'h2, 0,5'h00, 1,5'h12,28'h200, 0,0, 0,0, 4'h0};
      vt[6] = '{1,1,1, 4'h1,4'h2, 0,5'h00, 1,5'h01,28'h100, 1,0, 0,0, 4'h0};
      vt[7] = '{0,0,1, 4'h1,4'h2, 1,5'h07, 0,5'h00,28'h000, 0,0, 1,0, 4'h7};

      reset = 1'b0;
      p0_req_valid = 1; p0_req_rw = 0; p0_req_addr = 28'h100; p0_req_tag = 4'h3;
      p0_req_data_valid = 1; p0_req_data_bits = '1; p0_req_data_mask = 16'hFFFF;
      p1_req_valid = 1; p1_req_rw = 1; p1_req_addr = 28'h200; p1_req_tag = 4'h2;
      p1_req_data_valid = 1; p1_req_data_bits = '0; p1_req_data_mask = 16'h00FF;
      mem_req_ready = 1; mem_req_data_ready = 1;
      mem_resp_valid = 1; mem_resp_tag = 5'h13; mem_resp_data = 128'h55;

      // Outputs are forced inactive while reset is low.
      next_cycle(); next_cycle();
      @(negedge clk);
      chk("rst_mem_req_valid", 128'(mem_req_valid), 128'd0);
      chk("rst_p0_ready", 128'({p0_req_ready, p1_req_ready}), 128'd0);
      chk("rst_data", 128'({mem_req_data_valid, p0_req_data_ready, p1_req_data_ready}), 128'd0);
      chk("rst_resp", 128'({p0_resp_valid, p1_resp_valid}), 128'd0);

      next_cycle();
      reset = 1'b1;
      p0_req_data_valid = 0; p1_req_data_valid = 0; p1_req_rw = 0;

      for (int i = 0; i < 8; i++) begin
         p0_req_valid = vt[i].v0; p0_req_tag = vt[i].t0;
         p1_req_valid = vt[i].v1; p1_req_tag = vt[i].t1;
         mem_req_ready = vt[i].ready;
         mem_resp_valid = vt[i].rv; mem_resp_tag = vt[i].rtag;
         mem_resp_data = {4{32'h0C0D_E000 + 32'(i)}};
         @(negedge clk);
         chk($sformatf("v%0d_mem_req_valid", i), 128'(mem_req_valid), 128'(vt[i].e_valid));
         if (vt[i].e_valid) begin
            chk($sformatf("v%0d_mem_req_tag", i), 128'(mem_req_tag), 128'(vt[i].e_tag));
            chk($sformatf("v%0d_mem_req_addr", i), 128'(mem_req_addr), 128'(vt[i].e_addr));
         end
         chk($sformatf("v%0d_req_ready", i), 128'({p0_req_ready, p1_req_ready}),
             128'({vt[i].e_r0, vt[i].e_r1}));
         chk($sformatf("v%0d_resp_valid", i), 128'({p0_resp_valid, p1_resp_valid}),
             128'({vt[i].e_rv0, vt[i].e_rv1}));
         if (vt[i].e_rv0) begin
            chk($sformatf("v%0d_p0_resp_tag", i), 128'(p0_resp_tag), 128'(vt[i].e_rtag));
            chk($sformatf("v%0d_p0_resp_data", i), p0_resp_data, {4{32'h0C0D_E000 + 32'(i)}});
         end
         if (vt[i].e_rv1) begin
            chk($sformatf("v%0d_p1_resp_tag", i), 128'(p1_resp_tag), 128'(vt[i].e_rtag));
            chk($sformatf("v%0d_p1_resp_data", i), p1_resp_data, {4{32'h0C0D_E000 + 32'(i)}});
         end
         chk($sformatf("v%0d_no_data", i), 128'(mem_req_data_valid), 128'd0);
         next_cycle();
      end
      mem_resp_valid = 0;

      // Port 1 write (rr_last=0 so port 1 wins the tie); port 0 read stays pending.
      p0_req_valid = 1; p0_req_rw = 0; p0_req_tag = 4'h1;
      p1_req_valid = 1; p1_req_rw = 1; p1_req_tag = 4'h2;
      p1_req_data_valid = 1; p1_req_data_bits = beat_pat(0); p1_req_data_mask = 16'h0F0F;
      mem_req_ready = 1; mem_req_data_ready = 1;
      @(negedge clk);
      chk("wr_req_rw", 128'({mem_req_valid, mem_req_rw}), 128'b11);
      chk("wr_req_tag", 128'(mem_req_tag), 128'h12);
      chk("wr_req_addr", 128'(mem_req_addr), 128'h200);
      chk("wr_ready", 128'({p0_req_ready, p1_req_ready}), 128'b01);
      chk("wr_req_cycle_no_data", 128'({mem_req_data_valid, p1_req_data_ready}), 128'd0);
      next_cycle();
      p1_req_valid = 0;
      p0_req_data_valid = 1; p0_req_data_bits = '1;
      mem_req_data_ready = 0;
      begin
         int beat = 0;
         int cyc = 0;
         while (beat < BEATS && cyc < 16) begin
            p1_req_data_bits = beat_pat(beat);
            @(negedge clk);
            chk($sformatf("wd%0d_no_req", cyc), 128'({mem_req_valid, p0_req_ready}), 128'd0);
            chk($sformatf("wd%0d_p0_dready", cyc), 128'(p0_req_data_ready), 128'd0);
            chk($sformatf("wd%0d_p1_dready", cyc), 128'(p1_req_data_ready), 128'(mem_req_data_ready));
            chk($sformatf("wd%0d_dvalid", cyc), 128'(mem_req_data_valid), 128'd1);
            chk($sformatf("wd%0d_offset", cyc), 128'(mem_req_data_offset), 128'(beat));
            chk($sformatf("wd%0d_bits", cyc), mem_req_data_bits, beat_pat(beat));
            chk($sformatf("wd%0d_mask", cyc), 128'(mem_req_data_mask), 128'h0F0F);
            if (mem_req_data_ready) beat++;
            next_cycle();
            mem_req_data_ready = ~mem_req_data_ready;
            cyc++;
         end
         chk("wd_burst_done", 128'(beat), 128'(BEATS));
      end
      p1_req_data_valid = 0;
      @(negedge clk);
      chk("after_wr_p0_grant", 128'({mem_req_valid, mem_req_tag}), 128'({1'b1, 5'h01}));
      chk("after_wr_p0_ready", 128'(p0_req_ready), 128'd1);
      chk("after_wr_no_data", 128'({mem_req_data_valid, p0_req_data_ready}), 128'd0);

      // Port 0 write, abandoned by reset after 2 of 4 beats.
      next_cycle();
      p0_req_rw = 1; p0_req_addr = 28'h300; p0_req_data_valid = 1;
      p1_req_valid = 0;
      mem_req_ready = 1; mem_req_data_ready = 1;
      next_cycle();
      p0_req_valid = 0;
      for (int k = 0; k < 2; k++) begin
         p0_req_data_bits = beat_pat(k + 8);
         @(negedge clk);
         chk($sformatf("ab%0d_offset", k), 128'(mem_req_data_offset), 128'(k));
         chk($sformatf("ab%0d_p0_dready", k), 128'({mem_req_data_valid, p0_req_data_ready}), 128'b11);
         next_cycle();
      end
      reset = 0;
      @(negedge clk);
      chk("ab_rst_no_data", 128'({mem_req_data_valid, p0_req_data_ready}), 128'd0);
      next_cycle();
      reset = 1;
      // Tie right after reset: port 0 wins; data channel stays quiet.
      p0_req_valid = 1; p0_req_rw = 0; p0_req_tag = 4'h6;
      p1_req_valid = 1; p1_req_rw = 0; p1_req_tag = 4'h9;
      @(negedge clk);
      chk("ab_post_grant", 128'({mem_req_valid, mem_req_tag}), 128'({1'b1, 5'h06}));
      chk("ab_post_no_data", 128'({mem_req_data_valid, p0_req_data_ready}), 128'd0);
      next_cycle();
      p0_req_valid = 0; p1_req_rw = 1; p1_req_data_valid = 1;
      p1_req_data_bits = beat_pat(20);
      @(negedge clk);
      chk("ab_p1_wr_grant", 128'({mem_req_valid, mem_req_rw, mem_req_tag}), 128'({2'b11, 5'h19}));
      next_cycle();
      p1_req_valid = 0;
      @(negedge clk);
      chk("ab_new_burst_offset", 128'({mem_req_data_valid, mem_req_data_offset}), 128'({1'b1, 2'd0}));
      chk("ab_new_burst_bits", mem_req_data_bits, beat_pat(20));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single memory request channel between the instruction-cache refill port (port 0) and the data-cache port (port 1) ahead of the backup memory. It grants request slots round-robin, locks the write-data channel to the granted writer for a full 4-beat line, and routes read responses back by tag. It sits between the cores' cache-refill logic inside `riscv_top` and the top-level `mem_req_*`/`mem_resp_*` pins.

## Interface
- `MEM_ADDR_BITS`, 28: line address width (16-byte granularity).
- `MEM_DATA_BITS`, 128: beat width.
- `MEM_TAG_BITS`, 5: downstream tag width; upstream tags are `MEM_TAG_BITS-1` bits.
- `BEATS`, 4: data beats per line write; fixed power of two.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low.
- `pN_req_valid` / `pN_req_ready`  in / out  1  per-port request handshake (N = 0, 1).
- `pN_req_rw`  in  1  1 = write.
- `pN_req_addr`  in  MEM_ADDR_BITS  line address.
- `pN_req_tag`  in  MEM_TAG_BITS-1  requester tag.
- `pN_req_data_valid` / `pN_req_data_ready`  in / out  1  per-port write-data handshake.
- `pN_req_data_bits`  in  MEM_DATA_BITS  write beat.
- `pN_req_data_mask`  in  MEM_DATA_BITS/8  byte mask.
- `pN_resp_valid`  out  1  response beat for port N.
- `pN_resp_tag`  out  MEM_TAG_BITS-1  returned tag.
- `pN_resp_data`  out  MEM_DATA_BITS  response beat.
- `mem_req_valid`/`mem_req_ready`, `mem_req_rw`, `mem_req_addr`, `mem_req_tag`  out/in/out/out/out  downstream request.
- `mem_req_data_valid`/`mem_req_data_ready`, `mem_req_data_bits`, `mem_req_data_mask`, `mem_req_data_offset`  out/in/out/out/out (offset 2 bits)  downstream write data.
- `mem_resp_valid`, `mem_resp_tag`, `mem_resp_data`  in  downstream response.

## Operation
- States: `IDLE`, `WDATA`.
- IDLE: grant = the only valid port; if both are valid, the port not granted last (`rr_last`). Forward the granted port's request combinationally. `mem_req_tag = {port_id, pN_req_tag}`. `pN_req_ready = mem_req_ready & grant_N`.
- Handshake with `rw=0`: update `rr_last`, stay IDLE.
- Handshake with `rw=1`: update `rr_last`, latch `wr_owner`, clear `beat_cnt`, enter WDATA. Data beats presented during the request cycle are not accepted.
- WDATA: `mem_req_valid=0`, so no new request is granted. The data channel connects to `wr_owner` only. `mem_req_data_offset = beat_cnt`. Each data handshake increments `beat_cnt`. A handshake at `beat_cnt==BEATS-1` wraps the counter to 0 and returns to IDLE.
- The non-owner's `pN_req_data_ready` is always 0. Both data-ready outputs are 0 in IDLE.
- Responses carry no backpressure. `pN_resp_valid = mem_resp_valid & (mem_resp_tag[MSB]==N)`. Tag and data are passed through with the MSB stripped.
- Requesters must hold request fields stable while valid and not ready; the arbiter may re-arbitrate each IDLE cycle until a handshake occurs.

## Timing
- Request path: zero-cycle combinational pass-through; the grant is not registered.
- Response path: zero-cycle combinational demux.
- Write burst: 1 request cycle, then ≥ BEATS data cycles; back-to-back beats at full rate.
- The earliest next request after a write is the cycle after the last data handshake.
- Reset (`reset==0` at a posedge): state=IDLE, `rr_last`=1 so port 0 wins the first tie, `beat_cnt`=0, `wr_owner`=0.
- While `reset` is low, force `mem_req_valid`, `mem_req_data_valid`, all `pN_*_ready` and `pN_resp_valid` to 0.
- Reset mid-WDATA abandons the burst with no further data beats.
- Simultaneous response and new request: independent; both proceed the same cycle.

## Structure
- Shared package `mem_pkg`: `MEM_ADDR_BITS`, `MEM_DATA_BITS`, `MEM_TAG_BITS`, `BEATS`, and the state enum `{IDLE, WDATA}`.
- One natural sub-module, `rr_arb2`: a two-input round-robin grant with `rr_last` pointer, which advances on handshake.
- Muxes and counter live in `mem_arbiter`.

## Test plan
- Single read from port 0 (addr 0x0000100, tag 3) with `mem_req_ready=1` → `mem_req_tag=0x03`, same-cycle `p0_req_ready`. Response tag 0x03 → `p0_resp_valid=1`, `p1_resp_valid=0`.
- Both ports request reads continuously, tags 1 and 2 → grants alternate 0,1,0,1 starting with port 0 after reset; downstream tags 0x01, 0x12, 0x01, 0x12.
- Port 1 write (addr 0x0000200) with data beats A0..A3; `mem_req_data_ready` toggled every other cycle → offsets 0,1,2,3 appear in order. Port 0 read pending throughout receives no grant until the cycle after beat 3.
- Port 0 drives `p0_req_data_valid=1` during port 1's WDATA → `p0_req_data_ready=0` and no beat is forwarded from port 0.
- Assert reset after 2 of 4 write beats → the next cycle is IDLE with `beat_cnt=0`. A fresh read is then granted and `mem_req_data_valid` stays 0.
- Back-to-back responses with tags 0x10, 0x05, 0x1F → routed to p1 (tag 0), p0 (tag 5), p1 (tag 0xF) in the same cycles.
